// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: shared types and constants for the AXI master write scheduler.
//   sched_state_e  : scheduler FSM states (IDLE, ISSUE)
//   AXI_BURST_INCR : AWBURST encoding for INCR
//   AXI_SIZE_4B    : AWSIZE encoding for 4-byte beats
//   MST_MASK_W     : width of the requester field in AWID (upper bits)
//   TAG_W          : width of the rolling tag field in AWID (lower bits)
package axi_sched_pkg;

  localparam int unsigned MST_MASK_W = 2;
  localparam int unsigned TAG_W      = 2;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_e;

endpackage

// File: rtl/axi_rr_arb.sv
// axi_rr_arb: combinational round-robin arbiter. Searches the request vector
// starting at rr_ptr and wrapping, and returns the first active requester.
// Ports:
//   req     in  NUM_REQ    : request vector
//   rr_ptr  in  MST_MASK_W : index with highest priority this cycle (< NUM_REQ)
//   gnt     out NUM_REQ    : one-hot grant
//   gnt_idx out MST_MASK_W : index of the granted requester
//   gnt_any out 1          : some requester was granted
module axi_rr_arb
  import axi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]    req,
  input  logic [MST_MASK_W-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [MST_MASK_W-1:0] gnt_idx,
  output logic                  gnt_any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ, so one subtraction is enough to wrap
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (i == idx && !gnt_any && req[i]) begin
          gnt[i]  = 1'b1;
          gnt_idx = MST_MASK_W'(i);
          gnt_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_mst_wr_sched.sv
// axi_mst_wr_sched: write-request scheduler for the testbench AXI master.
// Arbitrates up to three requesters round-robin onto one AW channel, builds
// AWID as {requester index + 1, rolling per-requester tag}, and throttles
// issue against the outstanding-write limit of the W-channel driver.
//
// Build option: AXI_SCHED_BRESP_TRACK_EN
//   defined   : outstanding count retires on B handshake, bready follows count
//   undefined : outstanding count retires on wlast_hs, bready is 1 after reset
//
// Ports:
//   aclk, aresetn (async, active-low), srst (sync, active-high)
//   req_valid/req_ready    : per-requester request / one-cycle accept pulse
//   req_addr, req_len      : packed per-requester address and beats-1
//   awvalid..awid, awready : AXI AW channel
//   wlast_hs               : W driver last-beat handshake
//   bvalid, bready         : AXI B handshake
//   ostd_cnt               : writes currently outstanding
//   err_sticky             : outstanding-count underflow seen
module axi_mst_wr_sched
  import axi_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned AXI_ADDR_W      = 32,
  parameter int unsigned AXI_ID_W        = 4,
  parameter int unsigned MST_OSTDREQ_NUM = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           srst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AXI_ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]           req_len,
  output logic                           awvalid,
  input  logic                           awready,
  output logic [AXI_ADDR_W-1:0]          awaddr,
  output logic [7:0]                     awlen,
  output logic [2:0]                     awsize,
  output logic [1:0]                     awburst,
  output logic [AXI_ID_W-1:0]            awid,
  input  logic                           wlast_hs,
  input  logic                           bvalid,
  output logic                           bready,
  output logic [$clog2(MST_OSTDREQ_NUM):0] ostd_cnt,
  output logic                           err_sticky
);

  localparam int unsigned          CNT_W    = $clog2(MST_OSTDREQ_NUM) + 1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MST_OSTDREQ_NUM);
  localparam logic [MST_MASK_W-1:0] LAST_IDX = MST_MASK_W'(NUM_REQ - 1);

  sched_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic [MST_MASK_W-1:0] gidx_q, rr_q, rr_d;
  logic [TAG_W-1:0]      tag_q [NUM_REQ];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  bready_q;
  logic [AXI_ADDR_W-1:0] awaddr_q;
  logic [7:0]            awlen_q;
  logic [AXI_ID_W-1:0]   awid_q;

  logic                  aw_hs, accept, dec_ev;
  logic [AXI_ADDR_W-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [TAG_W-1:0]      sel_tag;
  logic [NUM_REQ-1:0]    arb_gnt;
  logic [MST_MASK_W-1:0] arb_idx;
  logic                  arb_any;

  assign aw_hs  = (state_q == ISSUE) && awready;
  assign accept = (state_q == IDLE) && (|req_ready_q);

`ifdef AXI_SCHED_BRESP_TRACK_EN
  logic unused_wlast;
  assign unused_wlast = wlast_hs;
  assign dec_ev       = bvalid & bready_q;
`else
  logic unused_bvalid;
  assign unused_bvalid = bvalid;
  assign dec_ev        = wlast_hs;
`endif

  // Priority for the next decision moves past the requester just issued.
  assign rr_d = aw_hs ? ((gidx_q == LAST_IDX) ? '0 : gidx_q + MST_MASK_W'(1)) : rr_q;

  axi_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_d),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (aw_hs && !dec_ev) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!aw_hs && dec_ev) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // FSM: state register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  state_q <= IDLE;
    else if (srst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM: next state. IDLE leaves on the cycle its accept pulse is visible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_ready_q) state_d = ISSUE;
      ISSUE:   if (awready)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. The grant is decided at the edge that lands in a free IDLE
  // cycle, using the count and pointer that cycle will hold, so req_ready is
  // a flop yet still shows in the same cycle a freed slot appears and AW
  // follows one cycle later.
  always_comb begin
    awvalid_d   = (state_d == ISSUE);
    req_ready_d = '0;
    if (state_d == IDLE && cnt_d < CNT_MAX && arb_any) req_ready_d = arb_gnt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      req_ready_q <= '0;
      awvalid_q   <= 1'b0;
      gidx_q      <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bready_q    <= 1'b0;
    end else if (srst) begin
      req_ready_q <= '0;
      awvalid_q   <= 1'b0;
      gidx_q      <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      awvalid_q   <= awvalid_d;
      if (|req_ready_d) gidx_q <= arb_idx;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`ifdef AXI_SCHED_BRESP_TRACK_EN
      bready_q    <= (cnt_q != '0);
`else
      bready_q    <= 1'b1;
`endif
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_len  = '0;
    sel_tag  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == MST_MASK_W'(i)) begin
        sel_addr = req_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
        sel_len  = req_len[i*8 +: 8];
        sel_tag  = tag_q[i];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr_q <= '0;
      awlen_q  <= '0;
      awid_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) tag_q[i] <= '0;
    end else if (srst) begin
      awaddr_q <= '0;
      awlen_q  <= '0;
      awid_q   <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) tag_q[i] <= '0;
    end else begin
      if (accept) begin
        awaddr_q <= sel_addr;
        awlen_q  <= sel_len;
        awid_q   <= AXI_ID_W'({gidx_q + MST_MASK_W'(1), sel_tag});
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (aw_hs && gidx_q == MST_MASK_W'(i)) tag_q[i] <= tag_q[i] + TAG_W'(1);
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign awvalid    = awvalid_q;
  assign awaddr     = awaddr_q;
  assign awlen      = awlen_q;
  assign awid       = awid_q;
  assign awsize     = AXI_SIZE_4B;
  assign awburst    = AXI_BURST_INCR;
  assign bready     = bready_q;
  assign ostd_cnt   = cnt_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_axi_mst_wr_sched.sv
// tb_axi_mst_wr_sched: directed self-checking bench for axi_mst_wr_sched.
module tb_axi_mst_wr_sched;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 32;

  logic                 aclk = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 srst = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr = '0;
  logic [NREQ*8-1:0]    req_len = '0;
  logic                 awvalid;
  logic                 awready = 1'b0;
  logic [AW-1:0]        awaddr;
  logic [7:0]           awlen;
  logic [2:0]           awsize;
  logic [1:0]           awburst;
  logic [3:0]           awid;
  logic                 wlast_hs = 1'b0;
  logic                 bvalid = 1'b0;
  logic                 bready;
  logic [2:0]           ostd_cnt;
  logic                 err_sticky;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  axi_mst_wr_sched #(
    .NUM_REQ         (NREQ),
    .AXI_ADDR_W      (AW),
    .AXI_ID_W        (4),
    .MST_OSTDREQ_NUM (4)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .srst       (srst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .awsize     (awsize),
    .awburst    (awburst),
    .awid       (awid),
    .wlast_hs   (wlast_hs),
    .bvalid     (bvalid),
    .bready     (bready),
    .ostd_cnt   (ostd_cnt),
    .err_sticky (err_sticky)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_srst();
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
  endtask

  task automatic set_req(input int unsigned i, input logic [AW-1:0] a, input logic [7:0] l);
    req_addr[i*AW +: AW] = a;
    req_len[i*8 +: 8]    = l;
  endtask

  // Returns at the falling edge of the first cycle showing awvalid.
  task automatic wait_aw(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(negedge aclk);
      if (awvalid) seen = 1'b1;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int unsigned nhs;
    logic        stall_seen;
    logic [3:0]  exp_id;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ostd", ostd_cnt, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_bready", bready, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;

`ifdef AXI_SCHED_BRESP_TRACK_EN
    awready = 1'b1;
    set_req(0, 32'h7000, 8'd1);
    req_valid = 3'b001;
    wait_aw("bt_aw0");
    wait_aw("bt_aw1");
    req_valid = '0;
    tick();
    @(negedge aclk);
    chk("bt_ostd2", ostd_cnt, 2);
    chk("bt_bready_on", bready, 1);
    wlast_hs = 1'b1;
    tick();
    tick();
    wlast_hs = 1'b0;
    @(negedge aclk);
    chk("bt_wlast_ignored", ostd_cnt, 2);
    bvalid = 1'b1;
    tick();
    tick();
    bvalid = 1'b0;
    @(negedge aclk);
    chk("bt_ostd0", ostd_cnt, 0);
    chk("bt_bready_lag", bready, 1);
    tick();
    @(negedge aclk);
    chk("bt_bready_off", bready, 0);
    chk("bt_err", err_sticky, 0);
`else
    // Single request from requester 1
    set_req(1, 32'h100, 8'd3);
    req_valid = 3'b010;
    @(negedge aclk);
    chk("single_no_early_ready", req_ready, 3'b000);
    tick();
    @(negedge aclk);
    chk("single_ready", req_ready, 3'b010);
    chk("single_no_early_aw", awvalid, 0);
    chk("bready_after_rst", bready, 1);
    tick();
    req_valid = '0;
    @(negedge aclk);
    chk("single_awvalid", awvalid, 1);
    chk("single_ready_pulse", req_ready, 3'b000);
    chk("single_awaddr", awaddr, 32'h100);
    chk("single_awlen", awlen, 3);
    chk("single_awid", awid, 4'b1000);
    chk("single_awsize", awsize, 3'b010);
    chk("single_awburst", awburst, 2'b01);
    tick();
    @(negedge aclk);
    chk("single_hold", awvalid, 1);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    @(negedge aclk);
    chk("single_aw_done", awvalid, 0);
    chk("single_ostd1", ostd_cnt, 1);
    wlast_hs = 1'b1;
    tick();
    wlast_hs = 1'b0;
    @(negedge aclk);
    chk("single_ostd0", ostd_cnt, 0);

    // Fairness: all three requesting, awready tied high
    do_srst();
    for (int unsigned i = 0; i < NREQ; i++) set_req(i, 32'(32'h1000 * (i + 1)), 8'(i + 1));
    awready   = 1'b1;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_aw($sformatf("fair_aw%0d", k));
      exp_id = 4'(((k % 3) + 1) * 4 + (k / 3));
      chk($sformatf("fair_awid%0d", k), awid, exp_id);
      chk($sformatf("fair_awaddr%0d", k), awaddr, 32'h1000 * ((k % 3) + 1));
      chk($sformatf("fair_awlen%0d", k), awlen, (k % 3) + 1);
      if (k == 5) req_valid = '0;
      tick();
      wlast_hs = 1'b1;
      tick();
      wlast_hs = 1'b0;
    end
    @(negedge aclk);
    chk("fair_ostd", ostd_cnt, 0);
    chk("fair_err", err_sticky, 0);
    chk("fair_idle", awvalid, 0);

    // Throttle at 4 outstanding
    do_srst();
    set_req(0, 32'h2000, 8'd7);
    req_valid  = 3'b001;
    nhs        = 0;
    stall_seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge aclk);
      if (awvalid && awready) nhs++;
      if (ostd_cnt == 3'd4 && req_ready != '0) stall_seen = 1'b1;
    end
    chk("thr_issued", nhs, 4);
    chk("thr_ostd4", ostd_cnt, 4);
    chk("thr_no_ready", stall_seen, 0);
    chk("thr_stalled", req_ready, 3'b000);
    wlast_hs = 1'b1;
    tick();
    wlast_hs = 1'b0;
    @(negedge aclk);
    chk("thr_ostd3", ostd_cnt, 3);
    chk("thr_ready", req_ready, 3'b001);
    wait_aw("thr_aw5");
    chk("thr_awid_wrap", awid, 4'b0100);
    req_valid = '0;
    tick();
    @(negedge aclk);
    chk("thr_ostd_back4", ostd_cnt, 4);

    // Collision: AW handshake and wlast_hs together
    wlast_hs = 1'b1;
    tick();
    wlast_hs = 1'b0;
    set_req(1, 32'h3000, 8'd0);
    req_valid = 3'b010;
    wait_aw("coll_aw");
    chk("coll_awid", awid, 4'b1000);
    wlast_hs  = 1'b1;
    req_valid = '0;
    tick();
    wlast_hs = 1'b0;
    @(negedge aclk);
    chk("coll_ostd", ostd_cnt, 3);
    chk("coll_aw_done", awvalid, 0);

    // Underflow
    do_srst();
    @(negedge aclk);
    chk("uflow_pre_err", err_sticky, 0);
    wlast_hs = 1'b1;
    tick();
    wlast_hs = 1'b0;
    @(negedge aclk);
    chk("uflow_ostd", ostd_cnt, 0);
    chk("uflow_err", err_sticky, 1);
    repeat (3) tick();
    @(negedge aclk);
    chk("uflow_sticky", err_sticky, 1);
    do_srst();
    @(negedge aclk);
    chk("uflow_srst_clear", err_sticky, 0);
    tick();

    // Mid-burst asynchronous reset
    set_req(1, 32'h4000, 8'd5);
    req_valid = 3'b010;
    awready   = 1'b1;
    wait_aw("mid_aw0");
    req_valid = '0;
    tick();
    awready = 1'b0;
    set_req(1, 32'h5000, 8'd9);
    req_valid = 3'b010;
    wait_aw("mid_aw1");
    chk("mid_awid_tag1", awid, 4'b1001);
    tick();
    aresetn = 1'b0;
    @(negedge aclk);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_ostd", ostd_cnt, 0);
    chk("mid_rst_awaddr", awaddr, 0);
    chk("mid_rst_awlen", awlen, 0);
    chk("mid_rst_awid", awid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_err", err_sticky, 0);
    set_req(0, 32'h6000, 8'd2);
    req_valid = 3'b011;
    tick();
    aresetn = 1'b1;
    awready = 1'b1;
    wait_aw("mid_post_aw0");
    chk("mid_post_awid0", awid, 4'b0100);
    chk("mid_post_awaddr0", awaddr, 32'h6000);
    wait_aw("mid_post_aw1");
    chk("mid_post_awid1", awid, 4'b1000);
    chk("mid_post_awaddr1", awaddr, 32'h5000);
    req_valid = '0;
    tick();
    @(negedge aclk);
    chk("mid_post_ostd", ostd_cnt, 2);
    chk("mid_post_idle", awvalid, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
